// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 width codes,
// FSM state encoding and the store byte-lane helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = 4'b0011 << {addr_lo[1], 1'b0};
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and applies
// sign or zero extension according to the funct3 width code.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Right-justify the selected lanes, then extend to 32 bits.
    always_comb begin
        shifted_s = word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    data = shifted_s;
            F3_BU:   data = {24'h000000, shifted_s[7:0]};
            F3_HU:   data = {16'h0000, shifted_s[15:0]};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: valid/ready request channel, programmable wait states,
// word-organised RAM with byte-lane writes and an extended-data response channel.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_L    = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

    logic [31:0]   mem_r [DEPTH_WORDS];
    state_e        state_r, state_nxt_s;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [2:0]    f3_r;
    logic          ready_r;
    logic          rsp_valid_r;
    logic [31:0]   rsp_rdata_r;
    logic          rsp_err_r;

    logic          accept_s;
    logic          access_s;
    logic          misalign_s;
    logic          range_err_s;
    logic          f3_err_s;
    logic          err_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   load_data_s;
    logic [3:0]    be_s;
    logic [31:0]   lanes_s;

    // ready_r is only ever set when the FSM is heading into IDLE, so it doubles as the IDLE flag.
    assign accept_s = req_valid && ready_r;
    assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);

    // Request legality, judged purely from the latched request.
    always_comb begin
        case (f3_r)
            F3_H, F3_HU: misalign_s = addr_r[0];
            F3_W:        misalign_s = (addr_r[1:0] != 2'b00);
            default:     misalign_s = 1'b0;
        endcase
        if (we_r) begin
            f3_err_s = !((f3_r == F3_B) || (f3_r == F3_H) || (f3_r == F3_W));
        end else begin
            f3_err_s = (f3_r == 3'b011) || (f3_r == 3'b110) || (f3_r == 3'b111);
        end
        range_err_s = (addr_r[31:2] >= DEPTH_L);
        err_s       = misalign_s || range_err_s || f3_err_s;
    end

    assign word_idx_s = addr_r[AW+1:2];
    assign rd_word_s  = mem_r[word_idx_s];
    assign be_s       = byte_enable(f3_r, addr_r[1:0]);
    assign lanes_s    = store_lanes(f3_r, wdata_r);

    dmem_load_align u_align (
        .word    (rd_word_s),
        .addr_lo (addr_r[1:0]),
        .funct3  (f3_r),
        .data    (load_data_s)
    );

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (access_s && we_r && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= lanes_s[8*i +: 8];
                end
            end
        end
    end

    // Next-state decode; WAIT is always visited so the access edge lands WAIT_CYCLES+1 after accept.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_WAIT;
                else          state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) state_nxt_s = ST_RESP;
                else               state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM, wait counter and request capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            f3_r    <= 3'b000;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            if (accept_s) begin
                cnt_r   <= WAIT_LOAD;
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                f3_r    <= req_funct3;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Response registers: loaded on the access edge, cleared on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else if (access_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_data_s;
            rsp_err_r   <= err_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus scoreboard queue,
// with extra instances for the zero and maximum wait-state builds.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_ready;
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Wait (bounded) for ready, present the request for one accept edge, return at edge+1.
    task automatic send_req(input int sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3);
        int n = 0;
        @(negedge clk);
        while (!req_ready[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready[sel]}, 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        req_valid[sel] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[sel] = 1'b0;
    endtask

    task automatic wait_rsp(input int sel, output int lat);
        lat = 0;
        while (!rsp_valid[sel] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_rsp(input int sel);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("rdata", rsp_rdata[sel], e.rdata);
            chk("err", {31'd0, rsp_err[sel]}, {31'd0, e.err});
        end
    endtask

    task automatic run_txn(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat);
        exp_t e;
        int lat;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        send_req(sel, we, addr, wdata, f3);
        wait_rsp(sel, lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        check_rsp(sel);
        @(posedge clk);
        #1;
        chk("rsp_done", {31'd0, rsp_valid[sel]}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready[0]}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid[0]}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata[0], 32'd0);
        chk({tag, "_rsp_err"},   {31'd0, rsp_err[0]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        exp_t e;
        reset_n = 1'b0; req_valid = 3'b000; rsp_ready = 1'b1;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'b000;

        //  we    addr          wdata         f3      exp_rdata     err
        add(1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
        add(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
        add(1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
        add(1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0);
        add(1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0);
        add(1'b0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 1'b0);
        add(1'b1, 32'h11,  32'hAABBCC7F, 3'b000, 32'h0,        1'b0);
        add(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD7FEF, 1'b0);
        add(1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1);
        add(1'b1, 32'h11,  32'h00005555, 3'b001, 32'h0,        1'b1);
        add(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD7FEF, 1'b0);
        add(1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1);
        add(1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1);
        add(1'b1, 32'h10,  32'h0,        3'b100, 32'h0,        1'b1);
        add(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD7FEF, 1'b0);
        add(1'b1, 32'h12,  32'h1234CAFE, 3'b001, 32'h0,        1'b0);
        add(1'b0, 32'h10,  32'h0,        3'b010, 32'hCAFE7FEF, 1'b0);
        add(1'b0, 32'h11,  32'h0,        3'b000, 32'h0000007F, 1'b0);
        add(1'b0, 32'h10,  32'h0,        3'b001, 32'h00007FEF, 1'b0);
        add(1'b0, 32'h10,  32'h0,        3'b000, 32'hFFFFFFEF, 1'b0);
        add(1'b1, 32'h0,   32'h11111111, 3'b010, 32'h0,        1'b0);
        add(1'b1, 32'h400, 32'h22222222, 3'b010, 32'h0,        1'b1);
        add(1'b0, 32'h0,   32'h0,        3'b010, 32'h11111111, 1'b0);
        add(1'b1, 32'h3FC, 32'h13579BDF, 3'b010, 32'h0,        1'b0);
        add(1'b0, 32'h3FC, 32'h0,        3'b010, 32'h13579BDF, 1'b0);
        add(1'b0, 32'h3FF, 32'h0,        3'b100, 32'h00000013, 1'b0);
        add(1'b1, 32'h20,  32'h0,        3'b010, 32'h0,        1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, req_ready[0]}, 32'd1);

        foreach (vecs[i]) begin
            run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                    vecs[i].exp_rdata, vecs[i].exp_err, 2);
        end

        // Zero and maximum wait-state builds.
        run_txn(1, 1'b1, 32'h8, 32'hAABBCCDD, 3'b010, 32'h0,        1'b0, 1);
        run_txn(1, 1'b0, 32'h8, 32'h0,        3'b010, 32'hAABBCCDD, 1'b0, 1);
        run_txn(2, 1'b1, 32'h8, 32'hAABBCCDD, 3'b010, 32'h0,        1'b0, 16);
        run_txn(2, 1'b0, 32'hA, 32'h0,        3'b101, 32'h0000AABB, 1'b0, 16);

        // Back-pressure, with a competing request held during and at the handshake.
        rsp_ready = 1'b0;
        e.rdata = 32'hCAFE7FEF; e.err = 1'b0;
        sb_q.push_back(e);
        send_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        wait_rsp(0, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        check_rsp(0);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata", rsp_rdata[0], 32'hCAFE7FEF);
            chk("bp_err", {31'd0, rsp_err[0]}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_idle_ready", {31'd0, req_ready[0]}, 32'd1);
        req_valid[0] = 1'b0;
        run_txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hCAFE7FEF, 1'b0, 2);

        // Reset while a store waits: the store must not land.
        send_req(0, 1'b1, 32'h20, 32'h12345678, 3'b010);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("rst_wait");
        #1 reset_n = 1'b1;
        run_txn(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 2);

        // Reset during the response: the committed store must stay.
        rsp_ready = 1'b0;
        send_req(0, 1'b1, 32'h20, 32'h12345678, 3'b010);
        wait_rsp(0, lat);
        chk("rst_resp_valid", {31'd0, rsp_valid[0]}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("rst_resp");
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        run_txn(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 1'b0, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
